// File: rtl/handshake_rx_buffer.sv
// rtl/handshake_rx_buffer.sv - four-phase send/ack receiver feeding a show-ahead valid/ready FIFO
module handshake_rx_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [WIDTH-1:0] dados,
  output logic             ack,
  output logic [1:0]       estado,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    level,
  output logic [7:0]       word_count
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ACK  = 2'b01;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             wr_en;
  logic             rd_en;

  // Fullness uses the pre-edge level, so a read on the same edge cannot make room for a write.
  assign full  = (level == CW'(DEPTH));
  assign wr_en = (state == S_IDLE) && send && !full;
  assign rd_en = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = wr_en ? S_ACK : S_IDLE;
      S_ACK:   state_next = send ? S_ACK : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack    = (state == S_ACK);
    estado = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      word_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr     <= wr_ptr + PW'(1);
        word_count <= word_count + 8'd1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: its contents are only visible through the empty mask below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= dados;
    end
  end

  always_comb begin
    out_valid = (level != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

endmodule
